// File: rtl/regport_rr_arbiter_if.sv
// Register-write port bus between the writeback requesters and the round-robin arbiter.
// The requester side drives master; the arbiter is attached through slave.
interface regport_rr_arbiter_if;
    logic [3:0] Req;
    logic [3:0] Last;
    logic       Ready;
    logic [4:0] A;
    logic [4:0] B;
    logic [4:0] C;
    logic [4:0] D;
    logic [3:0] Gnt;
    logic [1:0] Sel;
    logic       Busy;
    logic [4:0] Addr;
    logic       Err;

    modport master (
        output Req, Last, Ready, A, B, C, D,
        input  Gnt, Sel, Busy, Addr, Err
    );

    modport slave (
        input  Req, Last, Ready, A, B, C, D,
        output Gnt, Sel, Busy, Addr, Err
    );
endinterface

// File: rtl/regport_rr_arbiter.sv
// Four-way round-robin arbiter for the shared 5-bit register-file write address.
// A grant is held across a multi-beat transfer and force-released after MAX_BEATS beats.
module regport_rr_arbiter #(
    parameter int MAX_BEATS = 8,
    parameter int CNT_W     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    regport_rr_arbiter_if.slave   rp
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           r_state;
    logic [3:0]       r_gnt;
    logic [1:0]       r_sel;
    logic             r_busy;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_ptr;

    logic             w_pick_vld;
    logic [1:0]       w_pick_idx;
    logic [1:0]       w_try;
    logic             w_req_g;
    logic             w_last_g;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Walk from the farthest candidate back to Ptr so the nearest set bit wins.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = r_ptr;
        w_try      = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_try = r_ptr + 2'(k);
            if (rp.Req[w_try]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = w_try;
            end
        end
    end

    assign w_req_g   = rp.Req[r_sel];
    assign w_last_g  = rp.Last[r_sel];
    assign w_cnt_nxt = r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'd0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_ptr   <= 2'd0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_vld) begin
                        r_gnt   <= 4'b0001 << w_pick_idx;
                        r_sel   <= w_pick_idx;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!w_req_g) begin
                        // Requester withdrew: silent release, no error.
                        r_gnt   <= 4'b0000;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_ptr   <= r_sel + 2'd1;
                        r_state <= IDLE;
                    end else if (rp.Ready) begin
                        if (w_last_g || (w_cnt_nxt == MAX_CNT)) begin
                            r_gnt   <= 4'b0000;
                            r_busy  <= 1'b0;
                            r_cnt   <= '0;
                            r_ptr   <= r_sel + 2'd1;
                            r_err   <= !w_last_g;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= w_cnt_nxt;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= 4'b0000;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rp.Addr = 5'd0;
        if (r_busy) begin
            case (r_sel)
                2'd0:    rp.Addr = rp.A;
                2'd1:    rp.Addr = rp.B;
                2'd2:    rp.Addr = rp.C;
                default: rp.Addr = rp.D;
            endcase
        end
    end

    assign rp.Gnt  = r_gnt;
    assign rp.Sel  = r_sel;
    assign rp.Busy = r_busy;
    assign rp.Err  = r_err;

endmodule

// File: doc/regport_rr_arbiter.md
Name: regport_rr_arbiter

Overview:
- Round-robin arbiter that shares one 5-bit register-address path between four requesters.
- Generates the 2-bit select for the 4:1 5-bit address mux feeding the register-file write port, and holds a grant across multi-beat transfers.
- Sits between the pipeline stages or units that request writeback (e.g. ALU, MUL/DIV, load, link) and the register file write port.

Parameters:
- MAX_BEATS, 8: maximum beats one grant may hold the port. Legal range 1..15. At the limit the grant is force-released.
- CNT_W, 4: width of the beat counter. Must be at least ceil(log2(MAX_BEATS+1)).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Req  input  4  request per requester; bit i belongs to requester i.
- Last  input  4  bit i high means requester i is presenting its final beat.
- Ready  input  1  write port accepts a beat this cycle.
- A, B, C, D  input  5 each  register address offered by requesters 0..3.
- Gnt  output  4  one-hot grant, registered.
- Sel  output  2  index of the granted requester, registered; drives the address mux.
- Busy  output  1  a grant is active, registered.
- Addr  output  5  combinational mux of A/B/C/D by Sel when Busy=1; 5'd0 when Busy=0.
- Err  output  1  one-cycle pulse on a forced (timeout) release, registered.

Behaviour:
- Reset (reset=0, asynchronous) sets: state=IDLE, Gnt=0, Sel=0, Busy=0, Err=0, beat count=0, priority pointer Ptr=0. Addr is therefore 0.
- Ptr (2 bits) names the highest-priority requester. Search order is Ptr, Ptr+1, Ptr+2, Ptr+3, all mod 4.
- IDLE state:
  - Req==0: remain in IDLE, all outputs at idle values.
  - Req!=0 at edge t: at t+1 set Gnt to the one-hot of the first set bit in search order, Sel to its index, Busy=1, count=0. Go to BUSY.
  - Latency from Req to Gnt is 1 cycle.
- BUSY state, g = Sel:
  - Beat accepted at an edge where Ready=1 and Req[g]=1. Count increments by 1.
  - Normal release: accepted beat with Last[g]=1. Next cycle: Gnt=0, Busy=0, Ptr=g+1 mod 4, go to IDLE. Err stays 0.
  - Abort: Req[g]=0 at an edge, regardless of Ready/Last. Release exactly as in normal release; no Err.
  - Timeout: a beat is accepted that makes count==MAX_BEATS and Last[g]=0. Release as in normal release and Err=1 for exactly one cycle.
  - Last[g]=1 together with count reaching MAX_BEATS counts as normal release; no Err.
  - Ready=0: hold everything (Gnt, Sel, count). No timeout while stalled.
  - Changes on Req/Last of non-granted requesters are ignored while BUSY.
- Every release costs one IDLE bubble cycle. Back-to-back grants are spaced by at least 2 cycles of Busy edge activity. Re-arbitration uses the updated Ptr, so a requester holding Req continuously is served at most once per 4 grants when all requesters are contending.
- Gnt is always one-hot or zero. Gnt!=0 exactly when Busy=1. Sel is unchanged while Busy=0 (it keeps the last granted index).
- Reset asserted mid-transfer: immediate asynchronous return to reset values. Ptr also returns to 0.
- Addr width is 5 bits; there is no arithmetic on addresses.

Test Plan:
- Reset, then Req=4'b0000 for 5 cycles -> Gnt=0, Busy=0, Addr=0, Err=0 throughout.
- Req=4'b0101, A=5'd3, C=5'd9, Ready=1, Last[0]=1 on the first beat -> Gnt=0001, Sel=0, Addr=3 for 1 cycle; 1 idle cycle; then Gnt=0100, Sel=2, Addr=9.
- All four Req held high, each transfer ends with Last after 2 beats -> grant order 0,1,2,3,0; Busy pattern 1,1,0 repeating.
- Requester 1 granted with Ready toggling 1,0,1 and Last on the third accepted beat -> count holds during Ready=0; release after 3 accepted beats; Err=0.
- MAX_BEATS=8, requester 3 never asserts Last, Ready=1 -> release after the 8th beat, Err high for exactly 1 cycle, next priority goes to requester 0.
- Requester 2 drops Req mid-burst -> release next cycle with Err=0. Separately, assert reset during BUSY -> Gnt=0, Busy=0, Sel=0 immediately; after reset with Req=1000, requester 3 is granted (Ptr=0).
